// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
//   Shares one UDP TX FIFO pair (8-bit data FIFO + 96-bit status FIFO) between
//   REQ_NUMBER packet sources in the rx_xcvr_clk domain. One requester is granted
//   at a time, exactly len bytes are moved from its show-ahead FIFO into the data
//   FIFO, then the status word {mac, ip, len} is written to commit the packet.
//
//   Optional feature macro: UDP_TX_ARB_PRIORITY_EN
//     defined   -> requester 0 has strict priority, the rest are round-robin
//     undefined -> plain round-robin over all requesters
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   destination_mac/ip          client address, sampled when a grant is decided
//   req/req_len/req_data        per-requester packet-ready flag, length, head byte
//   req_rd                      per-requester pop strobe
//   grant/done/reject           one-hot grant, commit pulse, illegal-length pulse
//   tx_fifo_data/_write/_full   data FIFO write side
//   tx_fifo_status/_write/_full status FIFO write side
//   busy                        high whenever a packet is in flight
module udp_tx_arbiter #(
  parameter int REQ_NUMBER = 2,
  parameter int MAX_LEN    = 1472
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [47:0]              destination_mac,
  input  logic [31:0]              destination_ip,
  input  logic [REQ_NUMBER-1:0]    req,
  input  logic [REQ_NUMBER*16-1:0] req_len,
  input  logic [REQ_NUMBER*8-1:0]  req_data,
  output logic [REQ_NUMBER-1:0]    req_rd,
  output logic [REQ_NUMBER-1:0]    grant,
  output logic [REQ_NUMBER-1:0]    done,
  output logic [REQ_NUMBER-1:0]    reject,
  output logic [7:0]               tx_fifo_data,
  output logic                     tx_fifo_data_write,
  input  logic                     tx_fifo_data_full,
  output logic [95:0]              tx_fifo_status,
  output logic                     tx_fifo_status_write,
  input  logic                     tx_fifo_status_full,
  output logic                     busy
);

  localparam int IDX_W = $clog2(REQ_NUMBER);

  typedef enum logic [1:0] {IDLE, DATA, STATUS} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      gidx, rr_ptr, win_idx;
  logic                  win_valid, len_ok, start;
  logic [15:0]           win_len, len_q, cnt;
  logic [47:0]           mac_q;
  logic [31:0]           ip_q;
  logic [REQ_NUMBER-1:0] grant_q;
  int                    cand;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (int'(idx) == REQ_NUMBER - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Winner selection. The search walks from the RR pointer and wraps; with the
  // priority option requester 0 pre-empts the walk, and since the walk only
  // reaches index 0 when req[0] is low, no extra exclusion is needed.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
`ifdef UDP_TX_ARB_PRIORITY_EN
    if (req[0]) win_valid = 1'b1;
`endif
    for (int k = 0; k < REQ_NUMBER; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= REQ_NUMBER) cand = cand - REQ_NUMBER;
      if (!win_valid && req[IDX_W'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_len = req_len[{win_idx, 4'd0} +: 16];
  assign len_ok  = (win_len != 16'd0) && ({16'd0, win_len} <= 32'(MAX_LEN));
  assign start   = (state == IDLE) && win_valid && !tx_fifo_status_full;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and the per-cycle strobes. Data is a combinational pass-through
  // of the granted requester's show-ahead byte so no pipeline bubble is added.
  always_comb begin
    state_next           = state;
    req_rd               = '0;
    reject               = '0;
    done                 = '0;
    tx_fifo_data         = 8'd0;
    tx_fifo_data_write   = 1'b0;
    tx_fifo_status_write = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) state_next = DATA;
          else        reject[win_idx] = 1'b1;
        end
      end
      DATA: begin
        tx_fifo_data = req_data[{gidx, 3'd0} +: 8];
        if (!tx_fifo_data_full) begin
          req_rd[gidx]       = 1'b1;
          tx_fifo_data_write = 1'b1;
          if (cnt == 16'd1) state_next = STATUS;
        end
      end
      STATUS: begin
        if (!tx_fifo_status_full) begin
          tx_fifo_status_write = 1'b1;
          done[gidx]           = 1'b1;
          state_next           = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Packet context: winner, length, address snapshot, byte counter, RR pointer.
  // A rejected requester still moves the pointer so it cannot block the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      gidx    <= '0;
      rr_ptr  <= '0;
      len_q   <= 16'd0;
      cnt     <= 16'd0;
      mac_q   <= 48'd0;
      ip_q    <= 32'd0;
      grant_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= win_len;
            mac_q <= destination_mac;
            ip_q  <= destination_ip;
            if (len_ok) begin
              gidx             <= win_idx;
              cnt              <= win_len;
              grant_q          <= '0;
              grant_q[win_idx] <= 1'b1;
            end else begin
              rr_ptr <= next_ptr(win_idx);
            end
          end
        end
        DATA: begin
          if (!tx_fifo_data_full) cnt <= cnt - 16'd1;
        end
        STATUS: begin
          if (!tx_fifo_status_full) begin
            grant_q <= '0;
            rr_ptr  <= next_ptr(gidx);
          end
        end
        default: ;
      endcase
    end
  end

  assign grant          = grant_q;
  assign tx_fifo_status = {mac_q, ip_q, len_q};
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter
//   Randomised bench for udp_tx_arbiter. Each requester is a queue of packets
//   (length + bytes). A packet-level reference model decides winners from the
//   round-robin/priority rules and predicts every strobe, byte and status word.
module tb_udp_tx_arbiter;

  localparam int N       = 3;
  localparam int MAX_LEN = 1472;

  logic           clk = 1'b0;
  logic           reset;
  logic [47:0]    destination_mac;
  logic [31:0]    destination_ip;
  logic [N-1:0]   req;
  logic [N*16-1:0] req_len;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_rd, grant, done, reject;
  logic [7:0]     tx_fifo_data;
  logic           tx_fifo_data_write, tx_fifo_data_full;
  logic [95:0]    tx_fifo_status;
  logic           tx_fifo_status_write, tx_fifo_status_full;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // Requester FIFOs and the reference model's packet context.
  logic [15:0] pkt_len   [N][$];
  logic [7:0]  pkt_bytes [N][$];
  int          m_phase, m_g, m_rem, m_rr;
  logic [15:0] m_len;
  logic [47:0] m_mac;
  logic [31:0] m_ip;

  always #5 clk = ~clk;

  udp_tx_arbiter #(.REQ_NUMBER(N), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset),
    .destination_mac(destination_mac), .destination_ip(destination_ip),
    .req(req), .req_len(req_len), .req_data(req_data), .req_rd(req_rd),
    .grant(grant), .done(done), .reject(reject),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_data_write(tx_fifo_data_write),
    .tx_fifo_data_full(tx_fifo_data_full),
    .tx_fifo_status(tx_fifo_status), .tx_fifo_status_write(tx_fifo_status_write),
    .tx_fifo_status_full(tx_fifo_status_full), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int l);
    return (l >= 1) && (l <= MAX_LEN);
  endfunction

  function automatic int pick_winner(input logic [N-1:0] r, input int rr);
`ifdef UDP_TX_ARB_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (pkt_len[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // base < 0 gives random bytes, otherwise base, base+1, ...
  task automatic enqueue(input int i, input int len, input int base);
    pkt_len[i].push_back(16'(len));
    if (legal(len))
      for (int b = 0; b < len; b++)
        pkt_bytes[i].push_back(base < 0 ? 8'($urandom()) : 8'(base + b));
  endtask

  task automatic drive_inputs(input bit dfull, input bit sfull);
    tx_fifo_data_full   = dfull;
    tx_fifo_status_full = sfull;
    destination_mac     = {16'($urandom()), $urandom()};
    destination_ip      = $urandom();
    for (int i = 0; i < N; i++) begin
      req[i]              = (pkt_len[i].size() != 0);
      req_len[i*16 +: 16] = (pkt_len[i].size() != 0) ? pkt_len[i][0] : 16'h0;
      req_data[i*8 +: 8]  = (pkt_bytes[i].size() != 0) ? pkt_bytes[i][0] : 8'h00;
    end
  endtask

  task automatic applyStimulus(input bit dfull, input bit sfull);
    @(posedge clk);
    #1;
    drive_inputs(dfull, sfull);
  endtask

  // One cycle of the packet-level model, evaluated at the falling edge.
  task automatic model_cycle();
    logic [N-1:0] e_grant, e_rd, e_done, e_rej;
    logic         e_wr, e_swr, e_busy;
    logic [7:0]   e_data;
    logic [95:0]  e_status;
    int           g;
    logic [15:0]  l;
    @(negedge clk);
    e_grant = '0; e_rd = '0; e_done = '0; e_rej = '0;
    e_wr = 1'b0; e_swr = 1'b0; e_busy = 1'b0; e_data = 8'h0; e_status = 96'h0;
    case (m_phase)
      0: begin
        if (req != '0 && !tx_fifo_status_full) begin
          g = pick_winner(req, m_rr);
          if (g >= 0) begin
            l = req_len[g*16 +: 16];
            if (pkt_len[g].size() != 0) void'(pkt_len[g].pop_front());
            if (legal(int'(l))) begin
              m_phase = 1; m_g = g; m_rem = int'(l); m_len = l;
              m_mac = destination_mac; m_ip = destination_ip;
            end else begin
              e_rej[g] = 1'b1;
              m_rr = (g + 1) % N;
            end
          end
        end
      end
      1: begin
        e_grant[m_g] = 1'b1;
        e_busy = 1'b1;
        if (!tx_fifo_data_full) begin
          e_rd[m_g] = 1'b1;
          e_wr = 1'b1;
          if (pkt_bytes[m_g].size() != 0) e_data = pkt_bytes[m_g].pop_front();
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
      end
      default: begin
        e_grant[m_g] = 1'b1;
        e_busy = 1'b1;
        if (!tx_fifo_status_full) begin
          e_swr = 1'b1;
          e_done[m_g] = 1'b1;
          e_status = {m_mac, m_ip, m_len};
          m_rr = (m_g + 1) % N;
          m_phase = 0;
        end
      end
    endcase
    checkOutput("grant", grant, e_grant);
    checkOutput("req_rd", req_rd, e_rd);
    checkOutput("data_write", tx_fifo_data_write, e_wr);
    if (e_wr) checkOutput("data_byte", tx_fifo_data, e_data);
    checkOutput("status_write", tx_fifo_status_write, e_swr);
    if (e_swr) checkOutput("status_word", tx_fifo_status, e_status);
    checkOutput("done", done, e_done);
    checkOutput("reject", reject, e_rej);
    checkOutput("busy", busy, e_busy);
  endtask

  task automatic run_cycle(input bit dfull, input bit sfull);
    model_cycle();
    applyStimulus(dfull, sfull);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((m_phase != 0 || !queues_empty()) && n < bound) begin
      run_cycle(1'b0, 1'b0);
      n++;
    end
    checkOutput("drain_in_time", n < bound, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    m_phase = 0; m_g = 0; m_rem = 0; m_rr = 0;
    m_len = 16'h0; m_mac = 48'h0; m_ip = 32'h0;
    req = '0; req_len = '0; req_data = '0;
    tx_fifo_data_full = 1'b0; tx_fifo_status_full = 1'b0;
    destination_mac = 48'h0; destination_ip = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_grant", grant, '0);
    checkOutput("rst_req_rd", req_rd, '0);
    checkOutput("rst_done", done, '0);
    checkOutput("rst_reject", reject, '0);
    checkOutput("rst_data", tx_fifo_data, '0);
    checkOutput("rst_data_write", tx_fifo_data_write, '0);
    checkOutput("rst_status", tx_fifo_status, '0);
    checkOutput("rst_status_write", tx_fifo_status_write, '0);
    checkOutput("rst_busy", busy, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single packet A1..A4 from requester 0.
    enqueue(0, 4, 'hA1);
    drain(20);

    // Data FIFO full mid-packet, then status FIFO full while committing.
    enqueue(1, 6, 'hB0);
    for (int c = 0; c < 20; c++) run_cycle(c >= 3 && c <= 5, c >= 10 && c <= 12);
    drain(20);

    // Two requesters held with short packets: alternation.
    for (int p = 0; p < 3; p++) begin
      enqueue(0, 2, -1);
      enqueue(1, 2, -1);
    end
    drain(100);

    // Requester 1 mid-packet when 0 raises, then 1 re-requests.
    enqueue(1, 4, -1);
    repeat (3) run_cycle(1'b0, 1'b0);
    enqueue(0, 2, -1);
    enqueue(1, 2, -1);
    drain(50);

    // Illegal lengths on both ends of the range, then a legal one.
    enqueue(0, 0, -1);
    enqueue(1, MAX_LEN + 1, -1);
    enqueue(2, 3, -1);
    drain(50);

    // Largest legal packet.
    enqueue(2, MAX_LEN, -1);
    drain(MAX_LEN + 50);

    // Reset after 2 of 5 bytes.
    enqueue(1, 5, 'hC0);
    for (int c = 0; c < 30; c++) begin
      run_cycle(1'b0, 1'b0);
      if (m_phase == 1 && m_rem == 3) break;
    end
    checkOutput("reset_setup_bytes_left", m_rem, 3);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      pkt_len[i].delete();
      pkt_bytes[i].delete();
    end
    drive_inputs(1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_phase = 0; m_rr = 0; m_rem = 0;
    repeat (3) run_cycle(1'b0, 1'b0);

    // Random traffic with random back-pressure and occasional illegal lengths.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pkt_len[i].size() < 3 && $urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 19))
            0:       enqueue(i, 0, -1);
            1:       enqueue(i, MAX_LEN + 1, -1);
            2:       enqueue(i, 16'hFFFF, -1);
            default: enqueue(i, int'($urandom_range(1, 6)), -1);
          endcase
        end
      end
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end
    drain(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
